// File: rtl/mips_pkg.sv
// Shared definitions for the load-use interlock.
// Contents:
//   OPC_LW            opcode of the lw instruction
//   REG_ZERO          hard-wired zero register number (never a real hazard)
//   REMAIN_W          width of the stall-cycle down-counter (covers 1..7 cycles)
//   interlock_state_t interlock FSM states
package mips_pkg;

  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         REMAIN_W = 3;

  typedef enum logic {
    RUN,
    STALL
  } interlock_state_t;

endpackage

// File: rtl/load_use_interlock_reg_match.sv
// reg_match: combinational source/destination compare for the load-use interlock.
// Ports:
//   i_rs, i_rt        source register numbers of the IF/ID instruction
//   i_uses_rs/rt      IF/ID instruction really reads that source
//   i_wr              destination register of the load in ID/EX
//   o_hit             [1]=rs hit, [0]=rt hit
module reg_match (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rs,
  input  logic       i_uses_rt,
  input  logic [4:0] i_wr,
  output logic [1:0] o_hit
);

  assign o_hit = {i_uses_rs && (i_rs == i_wr),
                  i_uses_rt && (i_rt == i_wr)};

endmodule

// File: rtl/load_use_interlock.sv
// load_use_interlock: stalls the front end when a lw in ID/EX feeds the
// instruction in IF/ID, then pulses an EX forwarding select so the dependent
// instruction picks the load data from MEM/WB.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal flow; hazard drives stall outputs in the same cycle
// STALL | extra stall cycles for slow loads; r_remain counts them down
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   opcode_id_ex              opcode in ID/EX
//   regfile_write_num_id_ex   destination register in ID/EX
//   regfile_read_num1/2_if_id rs / rt in IF/ID
//   uses_rs_if_id/uses_rt_if_id  IF/ID instruction reads rs / rt
//   flush                     taken branch/jump flush of IF/ID
//   stall_pc, stall_if_id     hold PC / IF/ID
//   bubble_id_ex              inject NOP into ID/EX
//   load_fwd_ex               [1]=rs, [0]=rt take MEM/WB data in EX (one cycle)
//   stall_count               saturating count of stall cycles since reset
module load_use_interlock
  import mips_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,  // 1..7
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode_id_ex,
  input  logic [4:0]       regfile_write_num_id_ex,
  input  logic [4:0]       regfile_read_num1_if_id,
  input  logic [4:0]       regfile_read_num2_if_id,
  input  logic             uses_rs_if_id,
  input  logic             uses_rt_if_id,
  input  logic             flush,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic [1:0]       load_fwd_ex,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REMAIN_W-1:0] REMAIN_INIT = REMAIN_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

  interlock_state_t      r_state, w_state_nxt;
  logic [REMAIN_W-1:0]   r_remain, w_remain_nxt;
  logic [1:0]            r_match, w_match_nxt;
  logic [1:0]            r_fwd, w_fwd_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            w_hit;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_stall_out;

  reg_match u_reg_match (
    .i_rs      (regfile_read_num1_if_id),
    .i_rt      (regfile_read_num2_if_id),
    .i_uses_rs (uses_rs_if_id),
    .i_uses_rt (uses_rt_if_id),
    .i_wr      (regfile_write_num_id_ex),
    .o_hit     (w_hit)
  );

  // A load into $0 never produces a value worth waiting for.
  assign w_hazard = (opcode_id_ex == OPC_LW) &&
                    (regfile_write_num_id_ex != REG_ZERO) &&
                    !flush && (w_hit != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_remain <= '0;
      r_match  <= 2'b00;
      r_fwd    <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
      r_match  <= w_match_nxt;
      r_fwd    <= w_fwd_nxt;
    end
  end

  // The forwarding pulse is built only from registered state (r_match) or
  // latched at the hazard edge, so load_fwd_ex has no path from the inputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_remain_nxt = r_remain;
    w_match_nxt  = r_match;
    w_fwd_nxt    = 2'b00;
    w_stall      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_hazard) begin
          w_stall     = 1'b1;
          w_match_nxt = w_hit;
          if (LOAD_STALL_CYCLES == 1) begin
            w_fwd_nxt = w_hit;
          end else begin
            w_state_nxt  = STALL;
            w_remain_nxt = REMAIN_INIT;
          end
        end
      end
      STALL: begin
        if (flush) begin
          // The dependent instruction is being squashed: abandon the stall
          // and never raise the forwarding pulse for it.
          w_state_nxt  = RUN;
          w_match_nxt  = 2'b00;
          w_remain_nxt = '0;
        end else begin
          w_stall = 1'b1;
          if (r_remain == REMAIN_W'(1)) begin
            w_state_nxt  = RUN;
            w_remain_nxt = '0;
            w_fwd_nxt    = r_match;
          end else begin
            w_remain_nxt = r_remain - REMAIN_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  assign w_stall_out = w_stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall_out && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign stall_pc     = w_stall_out;
  assign stall_if_id  = w_stall_out;
  assign bubble_id_ex = w_stall_out;
  assign load_fwd_ex  = r_fwd & {2{!rst}};
  assign stall_count  = r_cnt & {CNT_W{!rst}};

endmodule

// File: tb/tb_load_use_interlock.sv
// Directed bench for load_use_interlock. Three instances share the stimulus:
// d1 (1 stall cycle, 16-bit counter), d3 (3 stall cycles), ds (1 cycle, 4-bit counter).
// Inputs change on the falling edge; outputs are sampled 2 ns later.
module tb_load_use_interlock;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] ADD = 6'b000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opc = 6'd0;
  logic [4:0] wr = 5'd0, rs = 5'd0, rt = 5'd0;
  logic       urs = 1'b0, urt = 1'b0, fl = 1'b0;

  logic        d1_sp, d1_si, d1_bb;  logic [1:0] d1_fw; logic [15:0] d1_cnt;
  logic        d3_sp, d3_si, d3_bb;  logic [1:0] d3_fw; logic [15:0] d3_cnt;
  logic        ds_sp, ds_si, ds_bb;  logic [1:0] ds_fw; logic [3:0]  ds_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_use_interlock #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .opcode_id_ex(opc), .regfile_write_num_id_ex(wr),
    .regfile_read_num1_if_id(rs), .regfile_read_num2_if_id(rt),
    .uses_rs_if_id(urs), .uses_rt_if_id(urt), .flush(fl),
    .stall_pc(d1_sp), .stall_if_id(d1_si), .bubble_id_ex(d1_bb),
    .load_fwd_ex(d1_fw), .stall_count(d1_cnt));

  load_use_interlock #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) d3 (
    .clk(clk), .rst(rst), .opcode_id_ex(opc), .regfile_write_num_id_ex(wr),
    .regfile_read_num1_if_id(rs), .regfile_read_num2_if_id(rt),
    .uses_rs_if_id(urs), .uses_rt_if_id(urt), .flush(fl),
    .stall_pc(d3_sp), .stall_if_id(d3_si), .bubble_id_ex(d3_bb),
    .load_fwd_ex(d3_fw), .stall_count(d3_cnt));

  load_use_interlock #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) ds (
    .clk(clk), .rst(rst), .opcode_id_ex(opc), .regfile_write_num_id_ex(wr),
    .regfile_read_num1_if_id(rs), .regfile_read_num2_if_id(rt),
    .uses_rs_if_id(urs), .uses_rt_if_id(urt), .flush(fl),
    .stall_pc(ds_sp), .stall_if_id(ds_si), .bubble_id_ex(ds_bb),
    .load_fwd_ex(ds_fw), .stall_count(ds_cnt));

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic set_in(input logic [5:0] o, input logic [4:0] w, input logic [4:0] s,
                        input logic [4:0] t, input logic us, input logic ut, input logic f);
    opc = o; wr = w; rs = s; rt = t; urs = us; urt = ut; fl = f;
  endtask

  task automatic set_idle();
    set_in(ADD, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // hazard pattern on the inputs while reset is held: outputs must stay 0
    set_in(LW, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);
    step(); #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw, d3_sp, d3_si, d3_bb, d3_fw, ds_sp, ds_si, ds_bb, ds_fw} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0",
               {d1_sp, d1_si, d1_bb, d1_fw, d3_sp, d3_si, d3_bb, d3_fw, ds_sp, ds_si, ds_bb, ds_fw});
    end
    set_idle();
    step(); rst = 1'b0; #2;
    checks++;
    if ({d1_cnt, d3_cnt, ds_cnt} !== 36'd0) begin
      errors++;
      $display("FAIL reset_count got=%h/%h/%h exp=0", d1_cnt, d3_cnt, ds_cnt);
    end
    checks++;
    if ({d1_sp, d1_fw, d3_sp, d3_fw} !== 6'd0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=0", {d1_sp, d1_fw, d3_sp, d3_fw});
    end
  endtask

  task automatic test_basic_stall();
    do_reset();
    set_in(LW, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0);
    #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw} !== 5'b11100) begin
      errors++; $display("FAIL c1_stall got=%b exp=11100", {d1_sp, d1_si, d1_bb, d1_fw});
    end
    step(); set_idle(); #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw} !== 5'b00010) begin
      errors++; $display("FAIL c1_fwd got=%b exp=00010", {d1_sp, d1_si, d1_bb, d1_fw});
    end
    checks++;
    if (d1_cnt !== 16'd1) begin
      errors++; $display("FAIL c1_count got=%0d exp=1", d1_cnt);
    end
    step(); #2;
    checks++;
    if ({d1_sp, d1_fw} !== 3'b000) begin
      errors++; $display("FAIL c1_fwd_clear got=%b exp=000", {d1_sp, d1_fw});
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    set_in(LW, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw $0
    #2;
    checks++;
    if ({d1_sp, d1_fw} !== 3'b000) begin
      errors++; $display("FAIL c2_zero got=%b exp=000", {d1_sp, d1_fw});
    end
    step(); set_in(LW, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);   // rt match but unused
    #2;
    checks++;
    if ({d1_sp, d1_fw} !== 3'b000) begin
      errors++; $display("FAIL c2_unused_rt got=%b exp=000", {d1_sp, d1_fw});
    end
    step(); set_in(ADD, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0);  // not a load
    #2;
    checks++;
    if ({d1_sp, d1_fw} !== 3'b000) begin
      errors++; $display("FAIL c2_not_lw got=%b exp=000", {d1_sp, d1_fw});
    end
    step(); set_in(LW, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1);   // flush in RUN
    #2;
    checks++;
    if ({d1_sp, d1_fw, d3_sp} !== 4'b0000) begin
      errors++; $display("FAIL c2_flush_run got=%b exp=0000", {d1_sp, d1_fw, d3_sp});
    end
    step(); set_idle(); #2;
    checks++;
    if ({d1_fw, d1_cnt, d3_cnt} !== 34'd0) begin
      errors++; $display("FAIL c2_after got fw=%b cnt=%0d/%0d exp=0", d1_fw, d1_cnt, d3_cnt);
    end
  endtask

  task automatic test_both_sources();
    do_reset();
    set_in(LW, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw} !== 5'b11100) begin
      errors++; $display("FAIL c3_stall got=%b exp=11100", {d1_sp, d1_si, d1_bb, d1_fw});
    end
    step(); set_idle(); #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw} !== 5'b00011) begin
      errors++; $display("FAIL c3_fwd got=%b exp=00011", {d1_sp, d1_si, d1_bb, d1_fw});
    end
  endtask

  task automatic test_multi_cycle();
    logic [4:0] exp_v [4];
    exp_v[0] = 5'b11100; exp_v[1] = 5'b11100; exp_v[2] = 5'b11100; exp_v[3] = 5'b00001;
    do_reset();
    set_in(LW, 5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step();
        if (i == 3) set_idle();
        else set_in(ADD, 5'd0, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);  // IF/ID held, ID/EX bubble
      end
      #2;
      checks++;
      if ({d3_sp, d3_si, d3_bb, d3_fw} !== exp_v[i]) begin
        errors++; $display("FAIL c4_cycle%0d got=%b exp=%b", i, {d3_sp, d3_si, d3_bb, d3_fw}, exp_v[i]);
      end
    end
    checks++;
    if (d3_cnt !== 16'd3) begin
      errors++; $display("FAIL c4_count got=%0d exp=3", d3_cnt);
    end
    step(); #2;
    checks++;
    if (d3_fw !== 2'b00) begin
      errors++; $display("FAIL c4_fwd_clear got=%b exp=00", d3_fw);
    end
  endtask

  task automatic test_flush_in_stall();
    do_reset();
    set_in(LW, 5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
    #2;
    checks++;
    if (d3_sp !== 1'b1) begin
      errors++; $display("FAIL c4f_first got=%b exp=1", d3_sp);
    end
    step(); set_in(ADD, 5'd0, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1);
    #2;
    checks++;
    if ({d3_sp, d3_si, d3_bb, d3_fw} !== 5'b00000) begin
      errors++; $display("FAIL c4f_flush got=%b exp=00000", {d3_sp, d3_si, d3_bb, d3_fw});
    end
    for (int i = 0; i < 3; i++) begin
      step(); set_idle(); #2;
      checks++;
      if ({d3_sp, d3_fw} !== 3'b000) begin
        errors++; $display("FAIL c4f_after%0d got=%b exp=000", i, {d3_sp, d3_fw});
      end
    end
    checks++;
    if (d3_cnt !== 16'd1) begin
      errors++; $display("FAIL c4f_count got=%0d exp=1", d3_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(LW, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    step(); set_in(ADD, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    #2;
    checks++;
    if ({d3_sp, d3_cnt} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL c5_pre got=%b cnt=%0d exp=1 cnt=1", d3_sp, d3_cnt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({d3_sp, d3_si, d3_bb, d3_fw, d3_cnt} !== 21'd0) begin
      errors++; $display("FAIL c5_async got=%b cnt=%0d exp=0", {d3_sp, d3_si, d3_bb, d3_fw}, d3_cnt);
    end
    step(); rst = 1'b0; set_idle(); #2;
    checks++;
    if ({d3_sp, d3_fw, d3_cnt} !== 19'd0) begin
      errors++; $display("FAIL c5_release got=%b cnt=%0d exp=0", {d3_sp, d3_fw}, d3_cnt);
    end
    step(); #2;
    checks++;
    if ({d3_sp, d3_fw, d3_cnt} !== 19'd0) begin
      errors++; $display("FAIL c5_run got=%b cnt=%0d exp=0", {d3_sp, d3_fw}, d3_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(LW, 5'd8, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0);
    step(); set_in(LW, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0);
    #2;
    checks++;
    if ({d1_sp, d1_si, d1_bb, d1_fw} !== 5'b11110) begin
      errors++; $display("FAIL b2b_overlap got=%b exp=11110", {d1_sp, d1_si, d1_bb, d1_fw});
    end
    step(); set_idle(); #2;
    checks++;
    if ({d1_sp, d1_fw, d1_cnt} !== {3'b001, 16'd2}) begin
      errors++; $display("FAIL b2b_second got=%b cnt=%0d exp=001 cnt=2", {d1_sp, d1_fw}, d1_cnt);
    end
  endtask

  task automatic test_saturate();
    int exp_c;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      set_in(LW, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
      step(); set_idle(); #2;
      exp_c = (i > 15) ? 15 : i;
      checks++;
      if (ds_cnt !== exp_c[3:0]) begin
        errors++; $display("FAIL sat_count%0d got=%0d exp=%0d", i, ds_cnt, exp_c);
      end
      step();
    end
    checks++;
    if (d1_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_wide got=%0d exp=20", d1_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stall();
    test_no_hazard();
    test_both_sources();
    test_multi_cycle();
    test_flush_in_stall();
    test_async_reset();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
